vga_sync_gen: RTL and testbench

- SVGA 800x600@60 timing generator clocked from the 240 MHz PLL output.
- Divides the clock by CLK_DIV (6) to produce the 40 MHz pixel-slot enable.
- Produces registered hsync, vsync, visible, pixel coordinates and frame strobe.
- Direct consumer of the PLL stage; downstream pixel/framebuffer logic keys off pix_en and x/y.

---
 rtl/vga_sync_gen.sv | 129 ++++++++++++
 tb/tb_vga_sync_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// SVGA 800x600@60 sync generator running from the 240 MHz PLL clock.
// A CLK_DIV divider produces the pixel-slot enable; position, sync, visible
// and frame strobe are registered and decoded from the next position so they
// change together with x/y.
// Optional: define VGA_TEST_PATTERN_EN to add the rgb colour-bar output.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 6,
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter bit          SYNC_POL  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  output logic        pix_en,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        visible,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [2:0]  rgb
`endif
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = $clog2(CLK_DIV);

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [10:0] XLast   = 11'(HTotal - 1);
  localparam logic [10:0] XVis    = 11'(H_VISIBLE);
  localparam logic [10:0] HsStart = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HsEnd   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  YLast   = 10'(VTotal - 1);
  localparam logic [9:0]  YVis    = 10'(V_VISIBLE);
  localparam logic [9:0]  VsStart = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VsEnd   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DivW-1:0] div_cnt;
  logic            adv;
  logic [10:0]     x_nx;
  logic [9:0]      y_nx;
  logic            vis_nx;
  logic            hs_nx;
  logic            vs_nx;
  logic            fs_nx;
  logic            eff_rst;

  assign eff_rst = rst | ~pll_locked;

  // Next position and its decode; only loaded on the divider wrap.
  always_comb begin
    adv    = (div_cnt == DivLast);
    x_nx   = (x == XLast) ? 11'd0 : x + 11'd1;
    y_nx   = y;
    if (x == XLast) begin
      y_nx = (y == YLast) ? 10'd0 : y + 10'd1;
    end
    vis_nx = (x_nx < XVis) && (y_nx < YVis);
    hs_nx  = ((x_nx >= HsStart) && (x_nx < HsEnd)) ? SYNC_POL : ~SYNC_POL;
    vs_nx  = ((y_nx >= VsStart) && (y_nx < VsEnd)) ? SYNC_POL : ~SYNC_POL;
    fs_nx  = (x_nx == 11'd0) && (y_nx == 10'd0);
  end

  // Divider, position and registered decode outputs.
  always_ff @(posedge clk) begin
    if (eff_rst) begin
      div_cnt     <= '0;
      x           <= XLast;
      y           <= YLast;
      pix_en      <= 1'b0;
      visible     <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else if (adv) begin
      div_cnt     <= '0;
      x           <= x_nx;
      y           <= y_nx;
      pix_en      <= 1'b1;
      visible     <= vis_nx;
      hsync       <= hs_nx;
      vsync       <= vs_nx;
      frame_start <= fs_nx;
    end else begin
      div_cnt     <= div_cnt + DivW'(1);
      pix_en      <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] rgb_nx;

  // Eight 100-pixel colour bars across the visible width.
  always_comb begin
    rgb_nx = 3'b000;
    if (vis_nx) begin
      if      (x_nx < 11'd100) rgb_nx = 3'b111;
      else if (x_nx < 11'd200) rgb_nx = 3'b110;
      else if (x_nx < 11'd300) rgb_nx = 3'b011;
      else if (x_nx < 11'd400) rgb_nx = 3'b010;
      else if (x_nx < 11'd500) rgb_nx = 3'b101;
      else if (x_nx < 11'd600) rgb_nx = 3'b100;
      else if (x_nx < 11'd700) rgb_nx = 3'b001;
      else                     rgb_nx = 3'b000;
    end
  end

  // Colour register, updated alongside x/y.
  always_ff @(posedge clk) begin
    if (eff_rst) begin
      rgb <= 3'b000;
    end else if (adv) begin
      rgb <= rgb_nx;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default-parameter instance for reset,
// line-0 horizontal timing, line wrap and lock loss, plus a reduced-size
// instance (CLK_DIV=2, 16x8 total, negative sync) for vertical and frame timing.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        pll_locked = 1'b1;
  logic        pix_en, visible, hsync, vsync, frame_start;
  logic [10:0] x;
  logic [9:0]  y;

  logic        rst_s = 1'b1;
  logic        pix_en_s, visible_s, hsync_s, vsync_s, frame_start_s;
  logic [10:0] x_s;
  logic [9:0]  y_s;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  rgb, rgb_s;
`endif

  int checks = 0;
  int errors = 0;

  vga_sync_gen dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pix_en      (pix_en),
    .x           (x),
    .y           (y),
    .visible     (visible),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .rgb         (rgb)
`endif
  );

  // Small frame: H 8+2+3+3=16 (hsync x 10..12), V 4+1+2+1=8 (vsync y 5..6).
  vga_sync_gen #(
    .CLK_DIV   (2),
    .H_VISIBLE (8),
    .H_FP      (2),
    .H_SYNC    (3),
    .H_BP      (3),
    .V_VISIBLE (4),
    .V_FP      (1),
    .V_SYNC    (2),
    .V_BP      (1),
    .SYNC_POL  (1'b0)
  ) dut_s (
    .clk         (clk),
    .rst         (rst_s),
    .pll_locked  (1'b1),
    .pix_en      (pix_en_s),
    .x           (x_s),
    .y           (y_s),
    .visible     (visible_s),
    .hsync       (hsync_s),
    .vsync       (vsync_s),
    .frame_start (frame_start_s)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .rgb         (rgb_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset hold
    tick(3);
    check("rst_x", 32'(x), 32'd1055);
    check("rst_y", 32'(y), 32'd627);
    check("rst_vis", 32'(visible), 32'd0);
    check("rst_pix_en", 32'(pix_en), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_hs", 32'(hsync), 32'd0);
    check("rst_vs", 32'(vsync), 32'd0);
    rst = 1'b0;
    tick(5);
    check("pre_adv_x", 32'(x), 32'd1055);
    check("pre_adv_pix_en", 32'(pix_en), 32'd0);
    tick(1);  // T=0: first advance
    check("first_x", 32'(x), 32'd0);
    check("first_y", 32'(y), 32'd0);
    check("first_vis", 32'(visible), 32'd1);
    check("first_fs", 32'(frame_start), 32'd1);
    check("first_pix_en", 32'(pix_en), 32'd1);
    check("first_hs", 32'(hsync), 32'd0);
    check("first_vs", 32'(vsync), 32'd0);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_x0", 32'(rgb), 32'd7);
`endif
    tick(1);
    check("pix_en_low", 32'(pix_en), 32'd0);
    check("fs_low", 32'(frame_start), 32'd0);
    check("x_hold", 32'(x), 32'd0);
    tick(5);  // T=6
    check("x1", 32'(x), 32'd1);
    check("pix_en_spacing", 32'(pix_en), 32'd1);
    tick(594);  // T=600
    check("x100", 32'(x), 32'd100);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_x100", 32'(rgb), 32'd6);
`endif
    tick(900);  // T=1500
    check("x250", 32'(x), 32'd250);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_x250", 32'(rgb), 32'd3);
`endif
    tick(3000);  // T=4500
    check("x750", 32'(x), 32'd750);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_x750", 32'(rgb), 32'd0);
`endif
    tick(294);  // T=4794
    check("x799", 32'(x), 32'd799);
    check("vis_799", 32'(visible), 32'd1);
    tick(6);  // T=4800
    check("x800", 32'(x), 32'd800);
    check("vis_800", 32'(visible), 32'd0);
    tick(234);  // T=5034
    check("x839", 32'(x), 32'd839);
    check("hs_839", 32'(hsync), 32'd0);
    tick(6);  // T=5040
    check("x840", 32'(x), 32'd840);
    check("hs_840", 32'(hsync), 32'd1);
    tick(762);  // T=5802
    check("x967", 32'(x), 32'd967);
    check("hs_967", 32'(hsync), 32'd1);
    tick(6);  // T=5808
    check("x968", 32'(x), 32'd968);
    check("hs_968", 32'(hsync), 32'd0);
    tick(522);  // T=6330
    check("x1055", 32'(x), 32'd1055);
    check("y0_end", 32'(y), 32'd0);
    tick(6);  // T=6336: line wrap
    check("wrap_x", 32'(x), 32'd0);
    check("wrap_y", 32'(y), 32'd1);
    check("wrap_vis", 32'(visible), 32'd1);
    check("wrap_fs", 32'(frame_start), 32'd0);
    tick(5400);  // x=900, y=1
    check("x900", 32'(x), 32'd900);
    check("hs_900", 32'(hsync), 32'd1);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_x900", 32'(rgb), 32'd0);
`endif
    // Lock loss mid-slot while hsync is active
    tick(2);
    pll_locked = 1'b0;
    tick(1);
    check("lock_x", 32'(x), 32'd1055);
    check("lock_y", 32'(y), 32'd627);
    check("lock_hs", 32'(hsync), 32'd0);
    check("lock_vis", 32'(visible), 32'd0);
    check("lock_pix_en", 32'(pix_en), 32'd0);
    pll_locked = 1'b1;
    tick(5);
    check("relock_pre_x", 32'(x), 32'd1055);
    tick(1);
    check("relock_x", 32'(x), 32'd0);
    check("relock_y", 32'(y), 32'd0);
    check("relock_fs", 32'(frame_start), 32'd1);

    // Reduced instance: vertical sync, frame wrap, negative polarity
    check("s_rst_x", 32'(x_s), 32'd15);
    check("s_rst_y", 32'(y_s), 32'd7);
    check("s_rst_hs", 32'(hsync_s), 32'd1);
    check("s_rst_vs", 32'(vsync_s), 32'd1);
    rst_s = 1'b0;
    tick(2);  // S=0
    check("s_first_x", 32'(x_s), 32'd0);
    check("s_first_y", 32'(y_s), 32'd0);
    check("s_first_fs", 32'(frame_start_s), 32'd1);
    check("s_first_vis", 32'(visible_s), 32'd1);
`ifdef VGA_TEST_PATTERN_EN
    check("s_rgb_x0", 32'(rgb_s), 32'd7);
`endif
    tick(94);  // S=94: (15,2)
    check("s_x15", 32'(x_s), 32'd15);
    check("s_y2", 32'(y_s), 32'd2);
    tick(2);  // (0,3)
    check("s_wrap_x", 32'(x_s), 32'd0);
    check("s_wrap_y", 32'(y_s), 32'd3);
    check("s_wrap_pix_en", 32'(pix_en_s), 32'd1);
    tick(62);  // S=158: (15,4)
    check("s_y4", 32'(y_s), 32'd4);
    check("s_vs_y4", 32'(vsync_s), 32'd1);
    check("s_vis_y4", 32'(visible_s), 32'd0);
    tick(2);  // (0,5)
    check("s_y5_x", 32'(x_s), 32'd0);
    check("s_vs_y5", 32'(vsync_s), 32'd0);
    tick(62);  // S=222: (15,6)
    check("s_vs_y6", 32'(vsync_s), 32'd0);
    tick(2);  // (0,7)
    check("s_y7", 32'(y_s), 32'd7);
    check("s_vs_y7", 32'(vsync_s), 32'd1);
    tick(18);  // (9,7)
    check("s_x9", 32'(x_s), 32'd9);
    check("s_hs_x9", 32'(hsync_s), 32'd1);
    tick(2);  // (10,7)
    check("s_hs_x10", 32'(hsync_s), 32'd0);
    tick(6);  // (13,7)
    check("s_x13", 32'(x_s), 32'd13);
    check("s_hs_x13", 32'(hsync_s), 32'd1);
    tick(4);  // S=254: (15,7)
    check("s_last_x", 32'(x_s), 32'd15);
    check("s_last_fs", 32'(frame_start_s), 32'd0);
`ifdef VGA_TEST_PATTERN_EN
    check("s_rgb_blank", 32'(rgb_s), 32'd0);
`endif
    tick(2);  // S=256: next frame
    check("s_frame_x", 32'(x_s), 32'd0);
    check("s_frame_y", 32'(y_s), 32'd0);
    check("s_frame_fs", 32'(frame_start_s), 32'd1);
    tick(1);
    check("s_fs_one_cycle", 32'(frame_start_s), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
